// File: rtl/vga_sync_monitor.sv
// Receive-side VGA sync checker: measures line/frame timing against the expected mode
// and reports per-line/per-frame errors, timeouts and mode lock.
module vga_sync_monitor #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned SYNC_POL    = 0,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned CW          = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync,
    input  logic          vsync,
    output logic [CW-1:0] h_total_meas,
    output logic [CW-1:0] h_sync_meas,
    output logic [CW-1:0] v_total_meas,
    output logic [CW-1:0] v_sync_meas,
    output logic          frame_done,
    output logic          frame_good,
    output logic          err,
    output logic          locked
);

    localparam int unsigned GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic          POL      = 1'(SYNC_POL);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] H_TOT_C  = CW'(H_TOTAL);
    localparam logic [CW-1:0] H_SYN_C  = CW'(H_SYNC);
    localparam logic [CW-1:0] V_TOT_C  = CW'(V_TOTAL);
    localparam logic [CW-1:0] V_SYN_C  = CW'(V_SYNC);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [GW-1:0] LOCK_C   = GW'(LOCK_FRAMES);
    localparam logic [GW-1:0] GONE_C   = GW'(1);

    logic          hs_a, vs_a;
    logic          hs_q, vs_q;
    logic          hs_lead, hs_trail, vs_lead, vs_trail;
    logic [CW-1:0] h_cnt, hp_cnt, v_cnt, vp_cnt;
    logic [CW-1:0] v_cnt_inc;
    logic          h_valid, v_valid, line_bad;
    logic [GW-1:0] good_cnt;
    logic          line_err, frame_eval, frame_ok, timeout;

    // Sync decode, edge detection and per-cycle check conditions
    always_comb begin
        hs_a       = (hsync == POL);
        vs_a       = (vsync == POL);
        hs_lead    = hs_a & ~hs_q;
        hs_trail   = ~hs_a & hs_q;
        vs_lead    = vs_a & ~vs_q;
        vs_trail   = ~vs_a & vs_q;
        // Line count including a lead that coincides with the vsync lead
        v_cnt_inc  = (hs_lead && (v_cnt != CNT_MAX)) ? v_cnt + ONE_C : v_cnt;
        timeout    = !hs_lead && (h_cnt == (CNT_MAX - ONE_C));
        line_err   = hs_lead && h_valid &&
                     ((h_cnt != H_TOT_C) || (h_sync_meas != H_SYN_C));
        frame_eval = vs_lead && v_valid;
        frame_ok   = (v_cnt_inc == V_TOT_C) && (v_sync_meas == V_SYN_C) &&
                     !line_bad && !line_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            hs_q <= hs_a;
            vs_q <= vs_a;
        end
    end

    // Horizontal period and sync-width measurement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt        <= '0;
            hp_cnt       <= '0;
            h_total_meas <= '0;
            h_sync_meas  <= '0;
        end else begin
            if (hs_lead) begin
                h_cnt        <= ONE_C;
                h_total_meas <= h_cnt;
            end else if (h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + ONE_C;
            end

            if (hs_lead) begin
                hp_cnt <= ONE_C;
            end else if (hs_a && (hp_cnt != CNT_MAX)) begin
                hp_cnt <= hp_cnt + ONE_C;
            end

            if (hs_trail) begin
                h_sync_meas <= hp_cnt;
            end
        end
    end

    // Vertical height and sync-width measurement, counted in hsync leads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_cnt        <= '0;
            vp_cnt       <= '0;
            v_total_meas <= '0;
            v_sync_meas  <= '0;
        end else begin
            if (vs_lead) begin
                v_total_meas <= v_cnt_inc;
                v_cnt        <= '0;
                vp_cnt       <= CW'(hs_lead);
            end else begin
                v_cnt <= v_cnt_inc;
                if (vs_a && hs_lead && (vp_cnt != CNT_MAX)) begin
                    vp_cnt <= vp_cnt + ONE_C;
                end
            end

            if (vs_trail) begin
                v_sync_meas <= vp_cnt;
            end
        end
    end

    // Validity, frame evaluation, error reporting and lock tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_valid    <= 1'b0;
            v_valid    <= 1'b0;
            line_bad   <= 1'b0;
            good_cnt   <= '0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            err        <= 1'b0;
        end else begin
            err        <= line_err | (frame_eval & ~frame_ok) | timeout;
            frame_done <= frame_eval;
            if (frame_eval) begin
                frame_good <= frame_ok;
            end

            if (timeout) begin
                h_valid <= 1'b0;
                v_valid <= 1'b0;
            end else begin
                if (hs_lead) h_valid <= 1'b1;
                if (vs_lead) v_valid <= 1'b1;
            end

            if (timeout || frame_eval) begin
                line_bad <= 1'b0;
            end else if (line_err) begin
                line_bad <= 1'b1;
            end

            if (timeout) begin
                good_cnt <= '0;
            end else if (frame_eval) begin
                if (!frame_ok) begin
                    good_cnt <= '0;
                end else if (good_cnt != LOCK_C) begin
                    good_cnt <= good_cnt + GONE_C;
                end
            end

            if (timeout || (frame_eval && !frame_ok)) begin
                locked <= 1'b0;
            end else begin
                locked <= (good_cnt == LOCK_C);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Self-checking bench for vga_sync_monitor: line-level stimulus checked against a
// frame/line reference model of the expected measurements, errors and lock state.
module tb_vga_sync_monitor;

    localparam int H_TOTAL     = 20;
    localparam int H_SYNC      = 3;
    localparam int V_TOTAL     = 6;
    localparam int V_SYNC      = 1;
    localparam int LOCK_FRAMES = 2;
    localparam int CW          = 12;
    localparam int SAT         = 4095;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hsync, vsync;
    logic [CW-1:0] h_total_meas, h_sync_meas, v_total_meas, v_sync_meas;
    logic          frame_done, frame_good, err, locked;

    always #5 clk = ~clk;

    vga_sync_monitor #(
        .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC),
        .SYNC_POL(0), .LOCK_FRAMES(LOCK_FRAMES), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .h_total_meas(h_total_meas), .h_sync_meas(h_sync_meas),
        .v_total_meas(v_total_meas), .v_sync_meas(v_sync_meas),
        .frame_done(frame_done), .frame_good(frame_good), .err(err), .locked(locked)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int err_pulses = 0;

    // Reference model state, updated once per line start
    bit m_hvalid, m_vvalid, m_line_bad, m_prev_vs, m_fg, m_period_known;
    int m_prev_period, m_hsync_meas, m_good_cnt, m_frame_lines, m_vs_run, m_vsync_meas;

    task automatic model_reset();
        m_hvalid = 0; m_vvalid = 0; m_line_bad = 0; m_prev_vs = 0; m_fg = 0;
        m_period_known = 0; m_prev_period = 0; m_hsync_meas = 0; m_good_cnt = 0;
        m_frame_lines = 0; m_vs_run = 0; m_vsync_meas = 0;
    endtask

    // One line: hsync active (low) for hw clocks out of p, vsync low for the whole line if vs
    task automatic drive_line(input int p, input int hw, input bit vs);
        bit bad_now, vs_lead, vs_trail, exp_err0, exp_fd, chk_vt, ht_known, exp_to;
        int exp_vt, exp_ht;
        bad_now  = m_hvalid && ((m_prev_period != H_TOTAL) || (m_hsync_meas != H_SYNC));
        exp_err0 = bad_now;
        exp_fd   = 0;
        chk_vt   = 0;
        exp_vt   = 0;
        ht_known = m_period_known;
        exp_ht   = m_prev_period;
        vs_lead  = vs && !m_prev_vs;
        vs_trail = !vs && m_prev_vs;
        m_hvalid = 1;
        if (vs_lead) begin
            exp_vt = m_frame_lines;
            chk_vt = m_vvalid;
            if (m_vvalid) begin
                exp_fd = 1;
                m_fg = (exp_vt == V_TOTAL) && (m_vsync_meas == V_SYNC) && !(m_line_bad || bad_now);
                if (m_fg) begin
                    if (m_good_cnt < LOCK_FRAMES) m_good_cnt++;
                end else begin
                    m_good_cnt = 0;
                    exp_err0 = 1;
                end
                m_line_bad = 0;
            end else begin
                m_line_bad = m_line_bad || bad_now;
            end
            m_vvalid = 1;
            m_frame_lines = 1;
            m_vs_run = 1;
        end else begin
            m_line_bad = m_line_bad || bad_now;
            m_frame_lines++;
            if (vs) m_vs_run++;
        end
        if (vs_trail) m_vsync_meas = m_vs_run;

        for (int c = 0; c < p; c++) begin
            hsync = (c < hw) ? 1'b0 : 1'b1;
            vsync = vs ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (err === 1'b1) err_pulses++;
            if (c == 0) begin
                n_checks++;
                if (err !== exp_err0) begin
                    n_fail++; $display("FAIL lead_err: got %b want %b at %0t", err, exp_err0, $time);
                end
                n_checks++;
                if (frame_done !== exp_fd) begin
                    n_fail++; $display("FAIL frame_done: got %b want %b at %0t", frame_done, exp_fd, $time);
                end
                n_checks++;
                if (frame_good !== m_fg) begin
                    n_fail++; $display("FAIL frame_good: got %b want %b at %0t", frame_good, m_fg, $time);
                end
                if (ht_known) begin
                    n_checks++;
                    if (h_total_meas !== CW'(exp_ht)) begin
                        n_fail++; $display("FAIL h_total_meas: got %0d want %0d at %0t", h_total_meas, exp_ht, $time);
                    end
                end
                if (chk_vt) begin
                    n_checks++;
                    if (v_total_meas !== CW'(exp_vt)) begin
                        n_fail++; $display("FAIL v_total_meas: got %0d want %0d at %0t", v_total_meas, exp_vt, $time);
                    end
                end
                if (vs_trail) begin
                    n_checks++;
                    if (v_sync_meas !== CW'(m_vsync_meas)) begin
                        n_fail++; $display("FAIL v_sync_meas: got %0d want %0d at %0t", v_sync_meas, m_vsync_meas, $time);
                    end
                end
            end else begin
                exp_to = (c == SAT - 1);
                if (exp_to) begin
                    m_hvalid = 0; m_vvalid = 0; m_good_cnt = 0; m_line_bad = 0;
                end
                n_checks++;
                if (err !== exp_to) begin
                    n_fail++; $display("FAIL line_err: got %b want %b at %0t", err, exp_to, $time);
                end
                if (c == 1) begin
                    n_checks++;
                    if (frame_done !== 1'b0) begin
                        n_fail++; $display("FAIL frame_done_pulse: got %b want 0 at %0t", frame_done, $time);
                    end
                end
            end
            if (c == p - 1) begin
                n_checks++;
                if (h_sync_meas !== CW'(hw)) begin
                    n_fail++; $display("FAIL h_sync_meas: got %0d want %0d at %0t", h_sync_meas, hw, $time);
                end
                n_checks++;
                if (locked !== (m_good_cnt == LOCK_FRAMES)) begin
                    n_fail++; $display("FAIL locked: got %b want %b at %0t", locked, (m_good_cnt == LOCK_FRAMES), $time);
                end
            end
        end
        m_prev_period  = (p > SAT) ? SAT : p;
        m_period_known = 1;
        m_hsync_meas   = hw;
        m_prev_vs      = vs;
    endtask

    task automatic drive_frame(input int nl, input int vsw, input int hw, input int st_idx, input int st_p);
        for (int i = 0; i < nl; i++) begin
            drive_line((i == st_idx) ? st_p : H_TOTAL, hw, (i < vsw));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        logic [4*CW+3:0] outs;
        outs = {h_total_meas, h_sync_meas, v_total_meas, v_sync_meas,
                frame_done, frame_good, err, locked};
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL %s: outputs 0x%0h want 0", tag, outs);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_nominal();
        for (int f = 0; f < 5; f++) drive_frame(V_TOTAL, V_SYNC, H_SYNC, -1, 0);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL nominal_lock: got %b want 1", locked);
        end
    endtask

    task automatic test_stretch();
        drive_frame(V_TOTAL, V_SYNC, H_SYNC, 2, H_TOTAL + 1);
        for (int f = 0; f < 3; f++) drive_frame(V_TOTAL, V_SYNC, H_SYNC, -1, 0);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL stretch_relock: got %b want 1", locked);
        end
    endtask

    task automatic test_long_frame();
        drive_frame(V_TOTAL + 1, V_SYNC, H_SYNC, -1, 0);
        drive_line(H_TOTAL, H_SYNC, 1'b1);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++; $display("FAIL long_frame_lock: got %b want 0", locked);
        end
        drive_frame(V_TOTAL - 1, 0, H_SYNC, -1, 0);
        for (int f = 0; f < 2; f++) drive_frame(V_TOTAL, V_SYNC, H_SYNC, -1, 0);
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_pulses;
        drive_line(4200, H_SYNC, 1'b0);
        n_checks++;
        if (err_pulses - e0 !== 1) begin
            n_fail++; $display("FAIL timeout_err_count: got %0d want 1", err_pulses - e0);
        end
        for (int f = 0; f < 4; f++) drive_frame(V_TOTAL, V_SYNC, H_SYNC, -1, 0);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL timeout_relock: got %b want 1", locked);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 8; c++) begin
            hsync = (c < 3) ? 1'b0 : 1'b1;
            vsync = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int f = 0; f < 4; f++) drive_frame(V_TOTAL, V_SYNC, H_SYNC, -1, 0);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL reset_relock: got %b want 1", locked);
        end
    endtask

    task automatic test_wide_hsync();
        for (int f = 0; f < 4; f++) drive_frame(V_TOTAL, V_SYNC, H_SYNC + 1, -1, 0);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++; $display("FAIL wide_lock: got %b want 0", locked);
        end
    endtask

    task automatic test_random();
        int nl, vsw, hw, st_idx, st_p, r;
        for (int f = 0; f < 20; f++) begin
            r   = $urandom_range(0, 9);
            nl  = (r == 0) ? V_TOTAL + 1 : (r == 1) ? V_TOTAL - 1 : V_TOTAL;
            vsw = ($urandom_range(0, 7) == 0) ? 2 : 1;
            hw  = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 2 : 4) : H_SYNC;
            st_idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            st_p   = ($urandom_range(0, 1) == 1) ? H_TOTAL - 1 : H_TOTAL + 1;
            drive_frame(nl, vsw, hw, st_idx, st_p);
        end
        for (int f = 0; f < 4; f++) drive_frame(V_TOTAL, V_SYNC, H_SYNC, -1, 0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nominal();
        test_stretch();
        test_long_frame();
        test_timeout();
        test_reset_mid();
        test_wide_hsync();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
